pss_sync_detector: RTL and testbench

- Complex matched-filter correlator plus sliding-window peak detector for 5G NR PSS time synchronisation.
- Sits after the 2x decimator. Its peak pulse marks the SSB timing that starts the FFT demodulator.
- Outputs are the correlation magnitude stream and a one-cycle peak strobe.

---
 rtl/pss_sync_pkg.sv | 35 +++
 rtl/pss_peak_window.sv | 71 +++++++
 rtl/pss_sync_detector.sv | 106 ++++++++++
 tb/tb_pss_sync_detector.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pss_sync_pkg.sv
// Shared helpers for the PSS correlator: accumulator sizing, conjugate complex multiply
// and unsigned saturation.
package pss_sync_pkg;

    localparam int CMUL_W    = 64;
    localparam int MAG_MAX_W = 128;

    typedef logic signed [CMUL_W-1:0] cmul_t;

    typedef struct packed {
        cmul_t re;
        cmul_t im;
    } cplx_t;

    function automatic int acc_width(input int in_dw, input int tap_dw, input int pss_len);
        return in_dw / 2 + tap_dw / 2 + $clog2(pss_len) + 1;
    endfunction

    // (xr + j*xi) * conj(tr + j*ti)
    function automatic cplx_t cmul_conj(input cmul_t xr, input cmul_t xi,
                                        input cmul_t tr, input cmul_t ti);
        cplx_t r;
        r.re = xr * tr + xi * ti;
        r.im = xi * tr - xr * ti;
        return r;
    endfunction

    function automatic logic [MAG_MAX_W-1:0] saturate(input logic [MAG_MAX_W-1:0] v,
                                                      input int out_dw);
        logic [MAG_MAX_W-1:0] lim;
        lim = {MAG_MAX_W{1'b1}} >> (MAG_MAX_W - out_dw);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/pss_peak_window.sv
// Sliding-window average peak detector on the correlation magnitude stream.
// Define PEAK_HOLDOFF_EN to suppress re-triggering for HOLDOFF_LEN magnitudes after a peak.
module pss_peak_window
    import pss_sync_pkg::*;
#(
    parameter int          DW            = 32,
    parameter int          WINDOW_LEN    = 8,
    parameter int unsigned DETECT_FACTOR = 4,
    parameter int unsigned MIN_PEAK      = 1,
    parameter int unsigned HOLDOFF_LEN   = 64
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic [DW-1:0] mag_i,
    input  logic          valid_i,
    output logic          peak_o
);

    localparam int LOG2W  = $clog2(WINDOW_LEN);
    localparam int SUM_W  = DW + LOG2W;
    localparam int CMP_W  = SUM_W + 32;
    localparam int FILL_W = $clog2(WINDOW_LEN + 1);
    localparam int HOLD_W = $clog2(HOLDOFF_LEN + 2);

`ifdef PEAK_HOLDOFF_EN
    localparam bit HOLDOFF_ON = 1'b1;
`else
    localparam bit HOLDOFF_ON = 1'b0;
`endif

    logic [DW-1:0]     win_q [WINDOW_LEN];
    logic [SUM_W-1:0]  sum_q;
    logic [FILL_W-1:0] fill_q;
    logic [HOLD_W-1:0] hold_q;
    logic [CMP_W-1:0]  thresh;
    logic              hit;
    logic              fire;

    // Threshold is formed at full width so a large average times the factor cannot wrap.
    always_comb begin
        thresh = CMP_W'(sum_q >> LOG2W) * CMP_W'(DETECT_FACTOR);
        hit    = (fill_q == FILL_W'(WINDOW_LEN))
              && (CMP_W'(mag_i) > thresh)
              && (CMP_W'(mag_i) >= CMP_W'(MIN_PEAK));
        fire   = hit && (hold_q == '0);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < WINDOW_LEN; i++) win_q[i] <= '0;
            sum_q  <= '0;
            fill_q <= '0;
            hold_q <= '0;
            peak_o <= 1'b0;
        end else begin
            peak_o <= valid_i && fire;
            if (valid_i) begin
                win_q[0] <= mag_i;
                for (int i = 1; i < WINDOW_LEN; i++) win_q[i] <= win_q[i-1];
                sum_q <= sum_q + SUM_W'(mag_i) - SUM_W'(win_q[WINDOW_LEN-1]);
                if (fill_q != FILL_W'(WINDOW_LEN)) fill_q <= fill_q + 1'b1;
                // Holdoff down-counter; stays at zero when the feature is compiled out.
                if (hold_q != '0)
                    hold_q <= hold_q - 1'b1;
                else if (HOLDOFF_ON && hit)
                    hold_q <= HOLD_W'(HOLDOFF_LEN);
            end
        end
    end

endmodule

// File: rtl/pss_sync_detector.sv
// PSS matched-filter correlator (2-stage pipeline) feeding a sliding-window peak detector.
// Optional PEAK_HOLDOFF_EN enables post-peak suppression inside pss_peak_window.
module pss_sync_detector
    import pss_sync_pkg::*;
#(
    parameter int                        IN_DW         = 32,
    parameter int                        TAP_DW        = 32,
    parameter int                        OUT_DW        = 32,
    parameter int                        PSS_LEN       = 128,
    parameter logic [TAP_DW*PSS_LEN-1:0] PSS_LOCAL     = '0,
    parameter int                        OUT_SHIFT     = 0,
    parameter int                        WINDOW_LEN    = 8,
    parameter int unsigned               DETECT_FACTOR = 4,
    parameter int unsigned               MIN_PEAK      = 1,
    parameter int unsigned               HOLDOFF_LEN   = 64
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [IN_DW-1:0]  s_axis_in_tdata,
    input  logic              s_axis_in_tvalid,
    output logic [OUT_DW-1:0] m_axis_corr_tdata,
    output logic              m_axis_corr_tvalid,
    output logic              peak_detected_o
);

    localparam int HALF_IN  = IN_DW / 2;
    localparam int HALF_TAP = TAP_DW / 2;
    localparam int ACC_W    = acc_width(IN_DW, TAP_DW, PSS_LEN);
    localparam int MAG_W    = 2 * ACC_W;

    logic [IN_DW-1:0]        hist_q [PSS_LEN];
    logic [IN_DW-1:0]        win    [PSS_LEN];
    cplx_t                   prod;
    logic signed [ACC_W-1:0] acc_re, acc_im;
    logic signed [ACC_W-1:0] re_q, im_q;
    logic signed [MAG_W-1:0] re_w, im_w;
    logic [MAG_W-1:0]        mag_full, mag_shift;
    logic [OUT_DW-1:0]       mag_q;
    logic                    v1_q, v2_q;

    // The incoming sample is correlated in the same cycle it is shifted in.
    always_comb begin
        win[0] = s_axis_in_tdata;
        for (int k = 1; k < PSS_LEN; k++) win[k] = hist_q[k-1];
    end

    always_comb begin
        prod   = '0;
        acc_re = '0;
        acc_im = '0;
        for (int k = 0; k < PSS_LEN; k++) begin
            prod = cmul_conj(
                cmul_t'($signed(win[k][HALF_IN-1:0])),
                cmul_t'($signed(win[k][IN_DW-1:HALF_IN])),
                cmul_t'($signed(PSS_LOCAL[TAP_DW*(PSS_LEN-1-k) +: HALF_TAP])),
                cmul_t'($signed(PSS_LOCAL[TAP_DW*(PSS_LEN-1-k) + HALF_TAP +: HALF_TAP])));
            acc_re = acc_re + ACC_W'(prod.re);
            acc_im = acc_im + ACC_W'(prod.im);
        end
    end

    always_comb begin
        re_w      = MAG_W'(re_q);
        im_w      = MAG_W'(im_q);
        mag_full  = $unsigned(re_w * re_w) + $unsigned(im_w * im_w);
        mag_shift = mag_full >> OUT_SHIFT;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int k = 0; k < PSS_LEN; k++) hist_q[k] <= '0;
            re_q  <= '0;
            im_q  <= '0;
            mag_q <= '0;
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
        end else begin
            v1_q <= s_axis_in_tvalid;
            v2_q <= v1_q;
            if (s_axis_in_tvalid) begin
                hist_q <= win;
                re_q   <= acc_re;
                im_q   <= acc_im;
            end
            if (v1_q) mag_q <= OUT_DW'(saturate(MAG_MAX_W'(mag_shift), OUT_DW));
        end
    end

    assign m_axis_corr_tdata  = mag_q;
    assign m_axis_corr_tvalid = v2_q;

    pss_peak_window #(
        .DW            (OUT_DW),
        .WINDOW_LEN    (WINDOW_LEN),
        .DETECT_FACTOR (DETECT_FACTOR),
        .MIN_PEAK      (MIN_PEAK),
        .HOLDOFF_LEN   (HOLDOFF_LEN)
    ) u_peak (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .mag_i   (mag_q),
        .valid_i (v2_q),
        .peak_o  (peak_detected_o)
    );

endmodule

// File: tb/tb_pss_sync_detector.sv
// Directed bench: three correlator instances share one input stream (16-bit out, 8-bit out,
// and a 2-tap asymmetric tap set), checked against hand-computed magnitudes and strobes.
module tb_pss_sync_detector;

    localparam int IN_DW   = 32;
    localparam int TAP_DW  = 32;
    localparam int PSS_LEN = 4;
    localparam logic [TAP_DW*PSS_LEN-1:0] TAPS   = {PSS_LEN{32'h0001_0000}};
    localparam logic [TAP_DW*2-1:0]       TAPS_C = {32'h0001_0000, 32'h0000_0001};

    logic             clk_i    = 1'b0;
    logic             reset_i  = 1'b1;
    logic [IN_DW-1:0] in_data  = '0;
    logic             in_valid = 1'b0;

    logic [15:0] corr_data;
    logic        corr_valid, peak;
    logic [7:0]  corr8_data;
    logic        corr8_valid, peak8;
    logic [15:0] corrc_data;
    logic        corrc_valid, peakc;

    int checks = 0;
    int errors = 0;
    int xr[4];
    int xi[4];
    int sum_re, sum_im;

    always #5 clk_i = ~clk_i;

    pss_sync_detector #(
        .IN_DW(IN_DW), .TAP_DW(TAP_DW), .OUT_DW(16), .PSS_LEN(PSS_LEN), .PSS_LOCAL(TAPS),
        .OUT_SHIFT(0), .WINDOW_LEN(8), .DETECT_FACTOR(4), .MIN_PEAK(1), .HOLDOFF_LEN(4)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .s_axis_in_tdata(in_data), .s_axis_in_tvalid(in_valid),
        .m_axis_corr_tdata(corr_data), .m_axis_corr_tvalid(corr_valid),
        .peak_detected_o(peak)
    );

    pss_sync_detector #(
        .IN_DW(IN_DW), .TAP_DW(TAP_DW), .OUT_DW(8), .PSS_LEN(PSS_LEN), .PSS_LOCAL(TAPS),
        .OUT_SHIFT(0), .WINDOW_LEN(8), .DETECT_FACTOR(4), .MIN_PEAK(1), .HOLDOFF_LEN(4)
    ) dut8 (
        .clk_i(clk_i), .reset_i(reset_i),
        .s_axis_in_tdata(in_data), .s_axis_in_tvalid(in_valid),
        .m_axis_corr_tdata(corr8_data), .m_axis_corr_tvalid(corr8_valid),
        .peak_detected_o(peak8)
    );

    pss_sync_detector #(
        .IN_DW(IN_DW), .TAP_DW(TAP_DW), .OUT_DW(16), .PSS_LEN(2), .PSS_LOCAL(TAPS_C),
        .OUT_SHIFT(0), .WINDOW_LEN(8), .DETECT_FACTOR(4), .MIN_PEAK(1), .HOLDOFF_LEN(4)
    ) dutc (
        .clk_i(clk_i), .reset_i(reset_i),
        .s_axis_in_tdata(in_data), .s_axis_in_tvalid(in_valid),
        .m_axis_corr_tdata(corrc_data), .m_axis_corr_tvalid(corrc_valid),
        .peak_detected_o(peakc)
    );

    task automatic clear_model();
        for (int k = 0; k < 4; k++) begin
            xr[k] = 0;
            xi[k] = 0;
        end
        sum_re = 0;
        sum_im = 0;
    endtask

    // One clock: inputs change on the falling edge, outputs are read 1 ns after the rising edge.
    task automatic drive(input logic v, input int re, input int im);
        @(negedge clk_i);
        in_valid = v;
        in_data  = {16'(im), 16'(re)};
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 0, 0);
    endtask

    // With all taps 0+1j the magnitude is |sum of last 4 samples|^2; pick the sample that
    // makes the running sum equal the requested target.
    task automatic send_sum(input int re, input int im);
        int nr, ni;
        nr = re - sum_re + xr[3];
        ni = im - sum_im + xi[3];
        for (int k = 3; k > 0; k--) begin
            xr[k] = xr[k-1];
            xi[k] = xi[k-1];
        end
        xr[0]  = nr;
        xi[0]  = ni;
        sum_re = re;
        sum_im = im;
        drive(1'b1, nr, ni);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        reset_i  = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        clear_model();
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        reset_i  = 1'b1;
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_i);
            #1;
            checks++;
            if ({corr_valid, corr_data, peak, corr8_valid, corr8_data, peak8,
                 corrc_valid, corrc_data, peakc} !== '0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: valid=%b data=%0d peak=%b, required all zero",
                         c, corr_valid, corr_data, peak);
            end
        end
        @(negedge clk_i);
        reset_i = 1'b0;
        clear_model();
        for (int c = 0; c < 20; c++) begin
            idle();
            checks++;
            if ({corr_valid, corr_data, peak, corr8_valid, corr8_data, peak8,
                 corrc_valid, corrc_data, peakc} !== '0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: valid=%b data=%0d peak=%b, required all zero",
                         c, corr_valid, corr_data, peak);
            end
        end
    endtask

    task automatic test_conjugate();
        logic exp_v;
        do_reset();
        for (int j = 0; j < 7; j++) begin
            if (j < 4) send_sum(0, j + 1);
            else idle();
            exp_v = (j >= 1) && (j <= 4);
            checks++;
            if (corr_valid !== exp_v) begin
                errors++;
                $display("FAIL conj_valid step %0d: got %b, required %b", j, corr_valid, exp_v);
            end
            if (j >= 1) begin
                checks++;
                if (corr_data !== 16'((j > 4 ? 4 : j) * (j > 4 ? 4 : j))) begin
                    errors++;
                    $display("FAIL conj_data step %0d: got %0d, required %0d",
                             j, corr_data, (j > 4 ? 4 : j) * (j > 4 ? 4 : j));
                end
            end
        end
    endtask

    task automatic test_valid_gaps();
        logic v, pv;
        int   n, pmag, exp_data;
        pv = 1'b0;
        n = 0;
        pmag = 0;
        exp_data = 0;
        do_reset();
        for (int j = 0; j < 10; j++) begin
            v = (j % 2 == 0) && (j < 8);
            if (v) begin
                n++;
                send_sum(0, n);
            end else begin
                idle();
            end
            if (pv) exp_data = pmag;
            checks++;
            if (corr_valid !== pv) begin
                errors++;
                $display("FAIL gap_valid step %0d: got %b, required %b", j, corr_valid, pv);
            end
            checks++;
            if (corr_data !== 16'(exp_data)) begin
                errors++;
                $display("FAIL gap_data step %0d: got %0d, required %0d", j, corr_data, exp_data);
            end
            pv   = v;
            pmag = n * n;
        end
    endtask

    task automatic test_peak();
        int sr[10] = '{1, 1, 1, 1, 1, 1, 1, 1, 4, 2};
        int si[10] = '{3, 3, 3, 3, 3, 3, 3, 3, 5, 6};
        logic exp_pk;
        do_reset();
        for (int j = 0; j < 12; j++) begin
            if (j < 10) send_sum(sr[j], si[j]);
            else idle();
            if (j == 9 || j == 10) begin
                checks++;
                if (corr_data !== (j == 9 ? 16'd41 : 16'd40)) begin
                    errors++;
                    $display("FAIL peak_mag step %0d: got %0d, required %0d",
                             j, corr_data, (j == 9 ? 41 : 40));
                end
            end
            exp_pk = (j == 10);
            checks++;
            if (peak !== exp_pk) begin
                errors++;
                $display("FAIL peak_strobe step %0d: got %b, required %b", j, peak, exp_pk);
            end
        end
    endtask

    task automatic test_back_to_back();
        int sr[14] = '{1, 1, 1, 1, 1, 1, 1, 1, 4, 1, 0, 2, 1, 0};
        int si[14] = '{3, 3, 3, 3, 3, 3, 3, 3, 5, 3, 10, 14, 3, 20};
`ifdef PEAK_HOLDOFF_EN
        logic [15:0] exp_mask = 16'h8400;
`else
        logic [15:0] exp_mask = 16'hB400;
`endif
        do_reset();
        for (int j = 0; j < 16; j++) begin
            if (j < 14) send_sum(sr[j], si[j]);
            else idle();
            checks++;
            if (peak !== exp_mask[j]) begin
                errors++;
                $display("FAIL b2b_strobe step %0d: got %b, required %b", j, peak, exp_mask[j]);
            end
        end
    endtask

    task automatic test_window_fill();
        do_reset();
        for (int j = 0; j < 5; j++) begin
            if (j == 0) send_sum(0, 0);
            else if (j == 1) send_sum(10, 30);
            else idle();
            checks++;
            if (peak !== 1'b0) begin
                errors++;
                $display("FAIL fill_strobe step %0d: got %b, required 0", j, peak);
            end
            if (j == 2) begin
                checks++;
                if (corr_data !== 16'd1000) begin
                    errors++;
                    $display("FAIL fill_mag: got %0d, required 1000", corr_data);
                end
            end
        end
    endtask

    task automatic test_saturation();
        int sr[3]   = '{8, 15, 16};
        int si[3]   = '{16, 0, 0};
        int exp16[3] = '{320, 225, 256};
        int exp8[3]  = '{255, 225, 255};
        do_reset();
        for (int j = 0; j < 5; j++) begin
            if (j < 3) send_sum(sr[j], si[j]);
            else idle();
            if (j >= 1 && j <= 3) begin
                checks++;
                if (corr8_valid !== 1'b1 || corr8_data !== 8'(exp8[j-1])) begin
                    errors++;
                    $display("FAIL sat8 step %0d: valid=%b data=%0d, required valid=1 data=%0d",
                             j, corr8_valid, corr8_data, exp8[j-1]);
                end
                checks++;
                if (corr_data !== 16'(exp16[j-1])) begin
                    errors++;
                    $display("FAIL sat16 step %0d: got %0d, required %0d",
                             j, corr_data, exp16[j-1]);
                end
            end
            checks++;
            if (peak8 !== 1'b0) begin
                errors++;
                $display("FAIL sat8_strobe step %0d: got %b, required 0", j, peak8);
            end
        end
    endtask

    // Taps (1, j): C = x[0]*conj(j) + x[1]*1, so order and conjugation both affect |C|^2.
    task automatic test_tap_order();
        do_reset();
        drive(1'b1, 1, 0);
        drive(1'b1, 0, 1);
        checks++;
        if (corrc_valid !== 1'b1 || corrc_data !== 16'd1) begin
            errors++;
            $display("FAIL tap_first: valid=%b data=%0d, required valid=1 data=1",
                     corrc_valid, corrc_data);
        end
        idle();
        checks++;
        if (corrc_valid !== 1'b1 || corrc_data !== 16'd4) begin
            errors++;
            $display("FAIL tap_second: valid=%b data=%0d, required valid=1 data=4",
                     corrc_valid, corrc_data);
        end
    endtask

    task automatic test_midstream_reset();
        do_reset();
        send_sum(0, 5);
        send_sum(0, 5);
        do_reset();
        #1;
        checks++;
        if (corr_valid !== 1'b0 || corr_data !== 16'd0) begin
            errors++;
            $display("FAIL midreset_clear: valid=%b data=%0d, required 0/0", corr_valid, corr_data);
        end
        send_sum(0, 1);
        idle();
        checks++;
        if (corr_valid !== 1'b1 || corr_data !== 16'd1) begin
            errors++;
            $display("FAIL midreset_history: valid=%b data=%0d, required valid=1 data=1",
                     corr_valid, corr_data);
        end
    endtask

    initial begin
        clear_model();
        test_reset();
        test_conjugate();
        test_valid_gaps();
        test_peak();
        test_back_to_back();
        test_window_fill();
        test_saturation();
        test_tap_order();
        test_midstream_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
